// File: rtl/video_clken_pkg.sv
// ---------------------------------------------------------------------------
// video_clken_pkg
// Shared definitions for the video clock-enable generator:
//   state_e          reconfiguration FSM states (IDLE / LOAD / SETTLE)
//   DEF_*            default widths and settle time used by the modules
//   freq_to_inc()    phase increment for a wanted output frequency
// ---------------------------------------------------------------------------
package video_clken_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam int DEF_NUM_CH      = 3;
  localparam int DEF_ACC_W       = 32;
  localparam int DEF_LOCK_CYCLES = 16;

  // inc = floor(f_out * 2^acc_w / f_ref). The result is truncated, so the
  // generated frequency is never above the requested one. Intended for
  // elaboration-time constants; f_out * 2^acc_w must fit in 64 bits.
  function automatic logic [63:0] freq_to_inc(input logic [63:0] f_ref_hz,
                                               input logic [63:0] f_out_hz,
                                               input int          acc_w);
    logic [63:0] scaled;
    scaled = f_out_hz << acc_w;
    return scaled / f_ref_hz;
  endfunction

endpackage

// File: rtl/video_clken_gen_if.sv
// ---------------------------------------------------------------------------
// video_clken_gen_if
// Reconfiguration request channel (valid/ready handshake).
//   cfg_valid  requester -> block  request present
//   cfg_ready  block -> requester  block can accept a request
//   cfg_ch     requester -> block  target channel index
//   cfg_inc    requester -> block  new phase increment (0 disables channel)
//   cfg_phase  requester -> block  accumulator value loaded with cfg_inc
// master = requester side, slave = video_clken_gen side.
// ---------------------------------------------------------------------------
interface video_clken_gen_if
  import video_clken_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ACC_W  = DEF_ACC_W
) ();

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc, cfg_phase,
    output cfg_ready
  );

endinterface

// File: rtl/video_nco_channel.sv
// ---------------------------------------------------------------------------
// video_nco_channel
// One phase-accumulator (NCO) channel.
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   i_load        load i_load_inc / i_load_phase this cycle (wins over add)
//   i_load_inc    new increment
//   i_load_phase  new accumulator value
//   o_en          one-cycle pulse the cycle after the accumulator wraps
//   o_msb         registered accumulator MSB (square wave), 0 when inc == 0
// ---------------------------------------------------------------------------
module video_nco_channel
  import video_clken_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_load_inc,
  input  logic [ACC_W-1:0] i_load_phase,
  output logic             o_en,
  output logic             o_msb
);

  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_acc;
  logic             r_en;
  logic             r_msb;
  logic [ACC_W:0]   w_sum;

  // Extra top bit is the wrap (carry) out of the modulo-2^ACC_W add.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inc <= '0;
      r_acc <= '0;
      r_en  <= 1'b0;
      r_msb <= 1'b0;
    end else if (i_load) begin
      r_inc <= i_load_inc;
      r_acc <= i_load_phase;
      r_en  <= 1'b0;
      // Gate with the incoming increment so a channel being disabled shows
      // a low square wave already in the cycle right after the load.
      r_msb <= (i_load_inc != '0) & r_acc[ACC_W-1];
    end else begin
      // With inc == 0 the sum equals r_acc and never carries, so the
      // accumulator holds and no enable is produced.
      r_acc <= w_sum[ACC_W-1:0];
      r_en  <= w_sum[ACC_W];
      r_msb <= (r_inc != '0) & r_acc[ACC_W-1];
    end
  end

  assign o_en  = r_en;
  assign o_msb = r_msb;

endmodule

// File: rtl/video_clken_gen.sv
// ---------------------------------------------------------------------------
// video_clken_gen
// Multi-channel NCO clock-enable generator with runtime reconfiguration.
//   refclk     sole clock, rising edge
//   rst        synchronous active-high reset
//   cfg        reconfiguration request channel (slave side)
//   outclk_en  per-channel one-cycle enable pulse on accumulator wrap
//   outclk     per-channel square wave (registered accumulator MSB)
//   locked     all channels settled since last reset / reconfiguration
// A request is accepted only in IDLE; the targeted channel is written in
// LOAD, then the block waits LOCK_CYCLES cycles (SETTLE) before accepting
// another request and reasserting locked.
// ---------------------------------------------------------------------------
module video_clken_gen
  import video_clken_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic              refclk,
  input  logic              rst,
  video_clken_gen_if.slave  cfg,
  output logic [NUM_CH-1:0] outclk_en,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES - 1);

  state_e           r_state,  w_state_next;
  logic [CNT_W-1:0] r_cnt,    w_cnt_next;
  logic             r_locked, w_locked_next;
  logic [CH_W-1:0]  r_ch,     w_ch_next;
  logic [ACC_W-1:0] r_inc,    w_inc_next;
  logic [ACC_W-1:0] r_phase,  w_phase_next;

  logic             w_hs;
  logic             w_ch_ok;
  logic [NUM_CH-1:0] w_load;

  assign cfg.cfg_ready = (r_state == ST_IDLE);
  assign w_hs          = cfg.cfg_valid && (r_state == ST_IDLE);
  // Widen before comparing: cfg_ch can encode indices past NUM_CH.
  assign w_ch_ok       = (32'(cfg.cfg_ch) < 32'(NUM_CH));

  // ---------------- FSM: next state / outputs ----------------
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_locked_next = r_locked;
    w_ch_next     = r_ch;
    w_inc_next    = r_inc;
    w_phase_next  = r_phase;
    case (r_state)
      ST_IDLE: begin
        // Out-of-range requests are consumed here and change nothing.
        if (w_hs && w_ch_ok) begin
          w_ch_next    = cfg.cfg_ch;
          w_inc_next   = cfg.cfg_inc;
          w_phase_next = cfg.cfg_phase;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_locked_next = 1'b0;
        w_cnt_next    = CNT_INIT;
        w_state_next  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_next  = ST_IDLE;
          w_locked_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a fresh settle period.
        w_state_next  = ST_SETTLE;
        w_cnt_next    = CNT_INIT;
        w_locked_next = 1'b0;
      end
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state  <= ST_SETTLE;
      r_cnt    <= CNT_INIT;
      r_locked <= 1'b0;
      r_ch     <= '0;
      r_inc    <= '0;
      r_phase  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_locked <= w_locked_next;
      r_ch     <= w_ch_next;
      r_inc    <= w_inc_next;
      r_phase  <= w_phase_next;
    end
  end

  assign locked = r_locked;

  // ---------------- channels ----------------
  // Only the targeted channel sees a load; all others keep accumulating.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_load[gi] = (r_state == ST_LOAD) && (r_ch == CH_W'(gi));

      video_nco_channel #(
        .ACC_W (ACC_W)
      ) u_nco (
        .clk          (refclk),
        .rst          (rst),
        .i_load       (w_load[gi]),
        .i_load_inc   (r_inc),
        .i_load_phase (r_phase),
        .o_en         (outclk_en[gi]),
        .o_msb        (outclk[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_video_clken_gen.sv
// ---------------------------------------------------------------------------
// tb_video_clken_gen
// A reference model advances on every refclk edge and pushes the expected
// outputs into a scoreboard queue; a monitor pops one entry per cycle on the
// falling edge and compares. The stimulus process adds directed checks with
// hand-computed counts (lock latency, enable counts and spacing).
// ---------------------------------------------------------------------------
module tb_video_clken_gen;
  import video_clken_pkg::*;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 32;
  localparam int L      = 16;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic              refclk = 1'b0;
  logic              rst    = 1'b1;
  logic [NUM_CH-1:0] outclk_en;
  logic [NUM_CH-1:0] outclk;
  logic              locked;

  video_clken_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg_if ();

  video_clken_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (L)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg       (cfg_if),
    .outclk_en (outclk_en),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] ck;
    logic              lk;
    logic              rdy;
  } exp_t;

  exp_t sb_q[$];

  // ---------------- reference model ----------------
  longint unsigned m_acc [NUM_CH];
  longint unsigned m_inc [NUM_CH];
  logic [NUM_CH-1:0] m_en, m_ck;
  logic            m_lk, m_rdy;
  longint          m_n          = 0;
  longint          m_load_edge  = -1;
  longint          m_ready_edge = 0;
  int              m_ld_ch      = 0;
  longint unsigned m_ld_inc     = 0;
  longint unsigned m_ld_ph      = 0;

  initial begin
    longint unsigned a, s;
    exp_t            e;
    forever begin
      @(posedge refclk);
      m_n++;
      if (rst) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_acc[i] = 0;
          m_inc[i] = 0;
        end
        m_en = '0;
        m_ck = '0;
        m_lk = 1'b0;
        m_rdy = 1'b0;
        m_load_edge  = -1;
        m_ready_edge = m_n + L;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          a = m_acc[i];
          if (m_n == m_load_edge && i == m_ld_ch) begin
            m_ck[i]  = (m_ld_inc != 0) ? a[31] : 1'b0;
            m_en[i]  = 1'b0;
            m_acc[i] = m_ld_ph;
            m_inc[i] = m_ld_inc;
          end else begin
            s = a + m_inc[i];
            m_en[i]  = (s >= MOD);
            m_ck[i]  = (m_inc[i] != 0) ? a[31] : 1'b0;
            m_acc[i] = s % MOD;
          end
        end
        if (m_n == m_load_edge) m_lk = 1'b0;
        if (m_rdy && cfg_if.cfg_valid === 1'b1) begin
          if (int'(cfg_if.cfg_ch) < NUM_CH) begin
            m_ld_ch      = int'(cfg_if.cfg_ch);
            m_ld_inc     = longint'(cfg_if.cfg_inc);
            m_ld_ph      = longint'(cfg_if.cfg_phase);
            m_load_edge  = m_n + 1;
            m_ready_edge = m_n + 1 + L;
            m_rdy        = 1'b0;
          end
        end
        if (m_n == m_ready_edge) begin
          m_rdy = 1'b1;
          m_lk  = 1'b1;
        end
      end
      e.en  = m_en;
      e.ck  = m_ck;
      e.lk  = m_lk;
      e.rdy = m_rdy;
      sb_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("outclk_en", 64'(outclk_en), 64'(e.en));
        check("outclk", 64'(outclk), 64'(e.ck));
        check("locked", 64'(locked), 64'(e.lk));
        check("cfg_ready", 64'(cfg_if.cfg_ready), 64'(e.rdy));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Returns #1 after the handshake edge.
  task automatic do_cfg(input int ch, input logic [31:0] inc, input logic [31:0] ph);
    int g;
    g = 0;
    while (cfg_if.cfg_ready !== 1'b1 && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) begin
      total++;
      bad++;
      $display("FAIL ready_wait: got cfg_ready=0 after %0d cycles expected 1", g);
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch[1:0];
    cfg_if.cfg_inc   = inc;
    cfg_if.cfg_phase = ph;
    $display("cfg: ch=%0d inc=0x%08h phase=0x%08h", ch, inc, ph);
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Samples from just after the handshake edge until ready and locked are
  // both back; also flags any ch0 enable spacing other than 4.
  task automatic measure_lock(output int rl, output int ll, output int g0bad);
    int g, last0;
    rl = 0; ll = 0; g0bad = 0; g = 0; last0 = -1;
    while (!(cfg_if.cfg_ready === 1'b1 && locked === 1'b1) && g < 100) begin
      if (cfg_if.cfg_ready !== 1'b1) rl++;
      if (locked !== 1'b1) ll++;
      if (outclk_en[0] === 1'b1) begin
        if (last0 >= 0 && (g - last0) != 4) g0bad++;
        last0 = g;
      end
      tick();
      g++;
    end
  endtask

  task automatic reset_and_lock(input string tag);
    int cnt;
    rst = 1'b0;
    cnt = 0;
    while (locked !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check({tag, "_lock_cycles"}, 64'(cnt), 64'(L));
    check({tag, "_ready_at_lock"}, 64'(cfg_if.cfg_ready), 64'd1);
  endtask

  initial begin
    int rl, ll, g0bad, n1, n0, last1, last0, gb1, gb0, nz;
    logic [63:0] inc_20m;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_inc   = '0;
    cfg_if.cfg_phase = '0;

    // Reset release: lock after exactly L cycles.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_ready", 64'(cfg_if.cfg_ready), 64'd0);
    check("rst_outs", 64'({outclk_en, outclk}), 64'd0);
    reset_and_lock("reset");

    // ch0 at a quarter of refclk.
    do_cfg(0, 32'h4000_0000, 32'h0);
    measure_lock(rl, ll, g0bad);
    check("ch0cfg_ready_low", 64'(rl), 64'(L + 1));
    check("ch0cfg_locked_low", 64'(ll), 64'(L));

    // ch1 at 20 MHz from 50 MHz; phase 0x80000000 makes 1000 adds give 400 wraps.
    inc_20m = freq_to_inc(64'd50_000_000, 64'd20_000_000, 32);
    do_cfg(1, inc_20m[31:0], 32'h8000_0000);
    tick();
    n1 = 0; n0 = 0; last1 = -1; last0 = -1; gb1 = 0; gb0 = 0;
    for (int j = 0; j < 1000; j++) begin
      tick();
      if (outclk_en[1] === 1'b1) begin
        if (last1 >= 0 && ((j - last1) < 2 || (j - last1) > 3)) gb1++;
        last1 = j;
        n1++;
      end
      if (outclk_en[0] === 1'b1) begin
        if (last0 >= 0 && (j - last0) != 4) gb0++;
        last0 = j;
        n0++;
      end
    end
    check("ch1_enables_1000", 64'(n1), 64'd400);
    check("ch1_gap_2or3", 64'(gb1), 64'd0);
    check("ch0_enables_1000", 64'(n0), 64'd250);
    check("ch0_gap_4", 64'(gb0), 64'd0);

    // Reconfigure ch2 while ch0 keeps running.
    do_cfg(2, 32'h1000_0000, 32'h0);
    measure_lock(rl, ll, g0bad);
    check("ch2cfg_ready_low", 64'(rl), 64'(L + 1));
    check("ch2cfg_locked_low", 64'(ll), 64'(L));
    check("ch2cfg_ch0_gap_4", 64'(g0bad), 64'd0);

    // Out-of-range channel (3 is the largest index the 2-bit field holds).
    do_cfg(3, 32'hDEAD_BEEF, 32'h1234_5678);
    rl = 0; ll = 0;
    for (int j = 0; j < 20; j++) begin
      if (cfg_if.cfg_ready !== 1'b1) rl++;
      if (locked !== 1'b1) ll++;
      tick();
    end
    check("badch_ready_low", 64'(rl), 64'd0);
    check("badch_locked_low", 64'(ll), 64'd0);

    // Hold valid (with a different increment) through the whole SETTLE.
    do_cfg(2, 32'h2000_0000, 32'h0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd2;
    cfg_if.cfg_inc   = 32'h0800_0000;
    measure_lock(rl, ll, g0bad);
    cfg_if.cfg_valid = 1'b0;
    check("held_ready_low", 64'(rl), 64'(L + 1));
    check("held_locked_low", 64'(ll), 64'(L));
    check("held_ch0_gap_4", 64'(g0bad), 64'd0);

    // Disable ch0: outputs low from the cycle after LOAD.
    do_cfg(0, 32'h0, 32'hFFFF_FFF0);
    tick();
    nz = 0;
    for (int j = 0; j < 30; j++) begin
      if (outclk[0] !== 1'b0 || outclk_en[0] !== 1'b0) nz++;
      tick();
    end
    check("ch0_off_outputs", 64'(nz), 64'd0);

    // Reset in the middle of SETTLE aborts and restarts the lock period.
    do_cfg(1, 32'h3000_0000, 32'h0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midrst_locked", 64'(locked), 64'd0);
    check("midrst_ready", 64'(cfg_if.cfg_ready), 64'd0);
    check("midrst_outs", 64'({outclk_en, outclk}), 64'd0);
    reset_and_lock("midrst");
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
